// File: rtl/wavelet_accel_pkg.sv
// Shared constants, register map and state encodings for the wavelet accelerator.
// Data and coefficients are signed Q16.16 words.
package wavelet_accel_pkg;

  localparam int INPUT_WIDTH      = 32;
  localparam int IBUFF_CELL_COUNT = 4096;
  localparam int OBUFF_CELL_COUNT = 4096;
  localparam int DATA_BUS_WIDTH   = 8;
  localparam int ADDR_BUS_WIDTH   = 32;
  localparam int MAX_FILTER_SIZE  = 32;
  localparam int FRAC_BITS        = 16;
  localparam int PROD_WIDTH       = 2 * INPUT_WIDTH;
  localparam int ACC_WIDTH        = PROD_WIDTH + 5;
  localparam int BUF_AW           = 12;
  localparam int BANK_AW          = 11;
  localparam int TAP_W            = 5;

  localparam logic [31:0] BASE_ADDRESS      = 32'h1A10_0000;
  localparam logic [1:0]  CONFIG_REG_OFFSET = 2'b00;
  localparam logic [1:0]  INPUT_REG_OFFSET  = 2'b01;
  localparam logic [1:0]  OUTPUT_REG_OFFSET = 2'b10;

  // CONFIG low-byte bit positions
  localparam int CFG_GO       = 0;
  localparam int CFG_INIT     = 1;
  localparam int CFG_RST_RPTR = 2;

  typedef enum logic [1:0] {IDLE, INIT_LOAD, GO_LOAD, COMPUTE} state_t;
  typedef enum logic [1:0] {E_IDLE, E_MAC, E_WRITE, E_FINAL} eng_state_t;

  function automatic logic [BUF_AW-1:0] decode_len(input logic [1:0] code);
    return 12'd256 << code;
  endfunction

endpackage

// File: rtl/wavelet_filter_engine.sv
// Dual-MAC DWT engine: walks levels, output index k and filter taps, producing
// detail words for the output buffer and approximations into the ping-pong bank.
module wavelet_filter_engine
  import wavelet_accel_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BUF_AW-1:0]      n_len,
  input  logic [1:0]             last_level,
  input  logic [TAP_W-1:0]       last_tap,
  input  logic [INPUT_WIDTH-1:0] hid_coef,
  input  logic [INPUT_WIDTH-1:0] lod_coef,
  input  logic [INPUT_WIDTH-1:0] rd_data,
  output logic [TAP_W-1:0]       tap,
  output logic [BUF_AW-1:0]      rd_addr,
  output logic                   buf_we,
  output logic [BUF_AW-1:0]      buf_waddr,
  output logic [INPUT_WIDTH-1:0] buf_wdata,
  output logic                   out_we,
  output logic [INPUT_WIDTH-1:0] out_wdata,
  output logic                   done
);

  eng_state_t state_q, state_d;

  logic [1:0]                  level_q;
  logic [BANK_AW-1:0]          k_q;
  logic [BANK_AW-1:0]          idx_q;
  logic [TAP_W-1:0]            tap_q;
  logic [BUF_AW-1:0]           m_len_q;
  logic                        src_bank_q;
  logic signed [ACC_WIDTH-1:0] acc_d_q, acc_a_q;

  logic signed [PROD_WIDTH-1:0] prod_d, prod_a;
  logic [BUF_AW-1:0]            idx_inc;
  logic [BANK_AW-1:0]           k_inc;
  logic                         idx_end, k_last, level_last;

  assign prod_d     = PROD_WIDTH'($signed(hid_coef)) * PROD_WIDTH'($signed(rd_data));
  assign prod_a     = PROD_WIDTH'($signed(lod_coef)) * PROD_WIDTH'($signed(rd_data));
  assign idx_inc    = {1'b0, idx_q} + 12'd1;
  assign idx_end    = (idx_inc == m_len_q);
  assign k_inc      = k_q + 11'd1;
  assign k_last     = ({1'b0, k_q} == (m_len_q >> 1) - 12'd1);
  assign level_last = (level_q == last_level);

  // Source samples come from the current bank; approximations go to the other one.
  assign tap       = tap_q;
  assign rd_addr   = {src_bank_q, idx_q};
  assign buf_waddr = {~src_bank_q, k_q};
  assign buf_wdata = acc_a_q[FRAC_BITS +: INPUT_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= E_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    out_we    = 1'b0;
    out_wdata = acc_d_q[FRAC_BITS +: INPUT_WIDTH];
    buf_we    = 1'b0;
    done      = 1'b0;
    case (state_q)
      E_IDLE:  if (start) state_d = E_MAC;
      E_MAC:   if (tap_q == last_tap) state_d = E_WRITE;
      E_WRITE: begin
        out_we = 1'b1;
        buf_we = 1'b1;
        if (k_last && level_last) state_d = E_FINAL;
        else                      state_d = E_MAC;
      end
      E_FINAL: begin
        out_we    = 1'b1;
        out_wdata = rd_data;
        if (idx_end) begin
          done    = 1'b1;
          state_d = E_IDLE;
        end
      end
      default: state_d = E_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q    <= '0;
      k_q        <= '0;
      idx_q      <= '0;
      tap_q      <= '0;
      m_len_q    <= '0;
      src_bank_q <= 1'b0;
      acc_d_q    <= '0;
      acc_a_q    <= '0;
    end else begin
      case (state_q)
        E_IDLE: if (start) begin
          level_q    <= '0;
          k_q        <= '0;
          idx_q      <= '0;
          tap_q      <= '0;
          m_len_q    <= n_len;
          src_bank_q <= 1'b0;
          acc_d_q    <= '0;
          acc_a_q    <= '0;
        end
        E_MAC: begin
          acc_d_q <= acc_d_q + ACC_WIDTH'(prod_d);
          acc_a_q <= acc_a_q + ACC_WIDTH'(prod_a);
          tap_q   <= tap_q + 5'd1;
          idx_q   <= idx_end ? '0 : idx_inc[BANK_AW-1:0];
        end
        E_WRITE: begin
          acc_d_q <= '0;
          acc_a_q <= '0;
          tap_q   <= '0;
          if (k_last) begin
            src_bank_q <= ~src_bank_q;
            m_len_q    <= m_len_q >> 1;
            k_q        <= '0;
            idx_q      <= '0;
            if (!level_last) level_q <= level_q + 2'd1;
          end else begin
            k_q   <= k_inc;
            idx_q <= {k_inc[BANK_AW-2:0], 1'b0};
          end
        end
        E_FINAL: idx_q <= idx_inc[BANK_AW-1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/wavelet_accelerator.sv
// Byte-bus front end for the DWT engine: address decode, CONFIG register,
// coefficient/input/output buffers and the load/compute state machine.
module wavelet_accelerator
  import wavelet_accel_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_BUS_WIDTH-1:0] cpu_data_in,
  input  logic [ADDR_BUS_WIDTH-1:0] cpu_addr_in,
  input  logic                      cpu_read_en_in,
  input  logic                      cpu_write_en_in,
  output logic [DATA_BUS_WIDTH-1:0] cpu_data_out,
  output logic                      cpu_data_ready
);

  state_t state_q, state_d;

  logic [1:0]             inputs_len_q, dec_level_q;
  logic [TAP_W-1:0]       filter_size_q;
  logic [BUF_AW-1:0]      out_rptr_q, out_count_q;
  logic [BANK_AW-1:0]     in_count_q;
  logic [5:0]             coef_cnt_q;
  logic [23:0]            in_word_q;

  logic [INPUT_WIDTH-1:0] hid_mem  [MAX_FILTER_SIZE];
  logic [INPUT_WIDTH-1:0] lod_mem  [MAX_FILTER_SIZE];
  logic [INPUT_WIDTH-1:0] ibuf     [IBUFF_CELL_COUNT];
  logic [INPUT_WIDTH-1:0] obuf     [OBUFF_CELL_COUNT];

  logic                   hit, wr, rd, cfg_wr0, cfg_wr1, in_wr, commit, pop, out_avail;
  logic [1:0]             lane, sel;
  logic [INPUT_WIDTH-1:0] commit_word;
  logic [BUF_AW-1:0]      n_len;
  logic                   coef_is_hid, go_start, eng_start;
  logic [5:0]             lod_sel;
  logic [15:0]            cfg_rd;
  logic [INPUT_WIDTH-1:0] rd_word;

  logic                   ibuf_we;
  logic [BUF_AW-1:0]      ibuf_waddr;
  logic [INPUT_WIDTH-1:0] ibuf_wdata;

  logic [TAP_W-1:0]       eng_tap;
  logic [BUF_AW-1:0]      eng_rd_addr, eng_buf_waddr;
  logic                   eng_buf_we, eng_out_we, eng_done;
  logic [INPUT_WIDTH-1:0] eng_buf_wdata, eng_out_wdata;

  assign hit         = (cpu_addr_in[31:4] == BASE_ADDRESS[31:4]);
  assign lane        = cpu_addr_in[1:0];
  assign sel         = cpu_addr_in[3:2];
  assign wr          = cpu_write_en_in & hit;
  assign rd          = cpu_read_en_in & hit;
  assign cfg_wr0     = wr && (sel == CONFIG_REG_OFFSET) && (lane == 2'd0);
  assign cfg_wr1     = wr && (sel == CONFIG_REG_OFFSET) && (lane == 2'd1);
  assign in_wr       = wr && (sel == INPUT_REG_OFFSET);
  assign commit      = in_wr && (lane == 2'd3);
  assign commit_word = {cpu_data_in, in_word_q};
  assign n_len       = decode_len(inputs_len_q);
  assign out_avail   = (out_rptr_q != out_count_q);
  assign pop         = rd && (sel == OUTPUT_REG_OFFSET) && (lane == 2'd3) && out_avail;
  assign coef_is_hid = (coef_cnt_q <= {1'b0, filter_size_q});
  assign lod_sel     = coef_cnt_q - {1'b0, filter_size_q} - 6'd1;
  assign go_start    = (state_q == IDLE) && (state_d == GO_LOAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    eng_start = 1'b0;
    case (state_q)
      IDLE: if (cfg_wr0 && !cpu_data_in[CFG_RST_RPTR]) begin
        if (cpu_data_in[CFG_INIT])    state_d = INIT_LOAD;
        else if (cpu_data_in[CFG_GO]) state_d = GO_LOAD;
      end
      INIT_LOAD: if (commit && coef_cnt_q == {filter_size_q, 1'b1}) state_d = IDLE;
      GO_LOAD: if (commit && {1'b0, in_count_q} == n_len - 12'd1) begin
        state_d   = COMPUTE;
        eng_start = 1'b1;
      end
      COMPUTE: if (eng_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inputs_len_q  <= '0;
      dec_level_q   <= '0;
      filter_size_q <= '0;
      out_rptr_q    <= '0;
      out_count_q   <= '0;
      in_count_q    <= '0;
      coef_cnt_q    <= '0;
      in_word_q     <= '0;
    end else begin
      if (pop) out_rptr_q <= out_rptr_q + 12'd1;
      if (cfg_wr0) begin
        if (cpu_data_in[CFG_RST_RPTR]) out_rptr_q <= '0;
        else if (state_q == IDLE) begin
          inputs_len_q <= cpu_data_in[4:3];
          dec_level_q  <= cpu_data_in[6:5];
        end
      end
      if (cfg_wr1 && state_q == IDLE) filter_size_q <= cpu_data_in[4:0];

      if (in_wr) begin
        case (lane)
          2'd0:    in_word_q[7:0]   <= cpu_data_in;
          2'd1:    in_word_q[15:8]  <= cpu_data_in;
          2'd2:    in_word_q[23:16] <= cpu_data_in;
          default: ;
        endcase
      end

      if (state_q == IDLE && state_d == INIT_LOAD) coef_cnt_q <= '0;
      else if (commit && state_q == INIT_LOAD)     coef_cnt_q <= coef_cnt_q + 6'd1;

      if (go_start)                              in_count_q <= '0;
      else if (commit && state_q == GO_LOAD)     in_count_q <= in_count_q + 11'd1;

      if (go_start)        out_count_q <= '0;
      else if (eng_out_we) out_count_q <= out_count_q + 12'd1;
    end
  end

  // Bank A is filled by the CPU; afterwards only the engine writes the scratch buffer.
  always_comb begin
    ibuf_we    = eng_buf_we;
    ibuf_waddr = eng_buf_waddr;
    ibuf_wdata = eng_buf_wdata;
    if (commit && state_q == GO_LOAD) begin
      ibuf_we    = 1'b1;
      ibuf_waddr = {1'b0, in_count_q};
      ibuf_wdata = commit_word;
    end
  end

  // NOTE: the buffers carry no reset; their contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (commit && state_q == INIT_LOAD) begin
      if (coef_is_hid) hid_mem[coef_cnt_q[TAP_W-1:0]] <= commit_word;
      else             lod_mem[lod_sel[TAP_W-1:0]]    <= commit_word;
    end
    if (ibuf_we)    ibuf[ibuf_waddr]  <= ibuf_wdata;
    if (eng_out_we) obuf[out_count_q] <= eng_out_wdata;
  end

  assign cfg_rd = {3'b000, filter_size_q, out_avail, dec_level_q, inputs_len_q, 1'b0,
                   state_q == INIT_LOAD, (state_q == GO_LOAD) || (state_q == COMPUTE)};

  always_comb begin
    rd_word = '0;
    if (rd) begin
      case (sel)
        CONFIG_REG_OFFSET: rd_word = {16'h0000, cfg_rd};
        OUTPUT_REG_OFFSET: if (out_avail) rd_word = obuf[out_rptr_q];
        default:           rd_word = '0;
      endcase
    end
  end

  always_comb begin
    case (lane)
      2'd0:    cpu_data_out = rd_word[7:0];
      2'd1:    cpu_data_out = rd_word[15:8];
      2'd2:    cpu_data_out = rd_word[23:16];
      default: cpu_data_out = rd_word[31:24];
    endcase
  end

  assign cpu_data_ready = rd;

  wavelet_filter_engine u_engine (
    .clk        (clk),
    .rst        (rst),
    .start      (eng_start),
    .n_len      (n_len),
    .last_level (dec_level_q),
    .last_tap   (filter_size_q),
    .hid_coef   (hid_mem[eng_tap]),
    .lod_coef   (lod_mem[eng_tap]),
    .rd_data    (ibuf[eng_rd_addr]),
    .tap        (eng_tap),
    .rd_addr    (eng_rd_addr),
    .buf_we     (eng_buf_we),
    .buf_waddr  (eng_buf_waddr),
    .buf_wdata  (eng_buf_wdata),
    .out_we     (eng_out_we),
    .out_wdata  (eng_out_wdata),
    .done       (eng_done)
  );

endmodule

// File: tb/tb_wavelet_accelerator.sv
// Directed bench for wavelet_accelerator: register map, coefficient load,
// Haar transforms at one and two levels, periodic wrap-around, pointer rewind, reset abort.
module tb_wavelet_accelerator;

  localparam logic [31:0] CFG_A  = 32'h1A10_0000;
  localparam logic [31:0] IN_A   = 32'h1A10_0004;
  localparam logic [31:0] OUT_A  = 32'h1A10_0008;
  localparam logic [31:0] UNUSED = 32'h1A10_000C;
  localparam logic [31:0] MISS_A = 32'h1A10_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din, dout;
  logic [31:0] addr;
  logic        re, we, rdy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wavelet_accelerator dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_data_in     (din),
    .cpu_addr_in     (addr),
    .cpu_read_en_in  (re),
    .cpu_write_en_in (we),
    .cpu_data_out    (dout),
    .cpu_data_ready  (rdy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; din = d; we = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [7:0] d, output logic r);
    @(negedge clk);
    addr = a; re = 1'b1;
    #1 d = dout; r = rdy;
    @(posedge clk);
    #1 re = 1'b0;
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] w);
    for (int b = 0; b < 4; b++) bus_wr(a + b, w[8*b +: 8]);
  endtask

  task automatic rd_word(input logic [31:0] a, output logic [31:0] w);
    logic [7:0] d;
    logic       r;
    for (int b = 0; b < 4; b++) begin
      bus_rd(a + b, d, r);
      w[8*b +: 8] = d;
    end
  endtask

  task automatic cfg_lo(output logic [7:0] d);
    logic r;
    bus_rd(CFG_A, d, r);
  endtask

  // kind 0: ramp x[i] = i in Q16.16; kind 1: unit impulse at index 0
  task automatic load_signal(input int kind);
    for (int i = 0; i < 256; i++)
      wr_word(IN_A, (kind == 0) ? 32'(i << 16) : ((i == 0) ? 32'h0001_0000 : 32'h0));
  endtask

  task automatic wait_idle(input string tag);
    logic [7:0] d;
    int         n = 0;
    cfg_lo(d);
    while (d[0] && n < 5000) begin
      cfg_lo(d);
      n++;
    end
    check(tag, 32'(d[0]), 32'h0);
  endtask

  // Hand-derived expected output streams.
  function automatic logic [31:0] exp_word(input int test, input int i);
    case (test)
      0: return (i < 128) ? 32'hFFFF_0000 : 32'((4 * (i - 128) + 1) << 16);
      1: return (i < 128) ? 32'hFFFF_0000 :
                (i < 192) ? 32'hFFFC_0000 : 32'((16 * (i - 192) + 6) << 16);
      default: return (i == 128 || i == 255) ? 32'h0001_0000 : 32'h0;
    endcase
  endfunction

  task automatic drain_check(input int test);
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      rd_word(OUT_A, w);
      check($sformatf("t%0d_out[%0d]", test, i), w, exp_word(test, i));
    end
  endtask

  initial begin
    logic [7:0]  d;
    logic        r;
    logic [31:0] w;

    rst = 1'b0; we = 1'b0; re = 1'b0; addr = '0; din = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    bus_rd(CFG_A, d, r);
    check("reset_cfg_lo", 32'(d), 32'h00);
    check("reset_ready", 32'(r), 32'h1);
    bus_rd(CFG_A + 1, d, r);
    check("reset_cfg_hi", 32'(d), 32'h00);
    bus_rd(MISS_A, d, r);
    check("miss_ready", 32'(r), 32'h0);
    check("miss_data", 32'(d), 32'h00);
    bus_rd(UNUSED, d, r);
    check("offset3_data", 32'(d), 32'h00);

    bus_wr(CFG_A, 8'hF8);
    bus_wr(CFG_A + 1, 8'h1F);
    rd_word(CFG_A, w);
    check("cfg_readback", w, 32'h0000_1F78);

    // Haar coefficients, F = 2
    bus_wr(CFG_A + 1, 8'h01);
    bus_wr(CFG_A, 8'h02);
    wr_word(IN_A, 32'h0001_0000);
    wr_word(IN_A, 32'hFFFF_0000);
    wr_word(IN_A, 32'h0001_0000);
    cfg_lo(d);
    check("init_busy_3", 32'(d), 32'h02);
    wr_word(IN_A, 32'h0001_0000);
    cfg_lo(d);
    check("init_done_4", 32'(d), 32'h00);

    // Haar, one level
    bus_wr(CFG_A, 8'h01);
    cfg_lo(d);
    check("go_busy", 32'(d), 32'h01);
    load_signal(0);
    wait_idle("haar1_done");
    cfg_lo(d);
    check("haar1_avail", 32'(d), 32'h80);
    drain_check(0);
    cfg_lo(d);
    check("haar1_empty", 32'(d), 32'h00);
    rd_word(OUT_A, w);
    check("haar1_empty_read", w, 32'h0);

    bus_wr(CFG_A, 8'h04);
    cfg_lo(d);
    check("rewind_avail", 32'(d), 32'h80);
    rd_word(OUT_A, w);
    check("rewind_word0", w, 32'hFFFF_0000);

    // Haar, two levels
    bus_wr(CFG_A, 8'h04);
    bus_wr(CFG_A, 8'h21);
    load_signal(0);
    wait_idle("haar2_done");
    drain_check(1);

    // Periodic wrap-around, F = 4, box low-pass
    bus_wr(CFG_A + 1, 8'h03);
    bus_wr(CFG_A, 8'h02);
    for (int j = 0; j < 4; j++) wr_word(IN_A, 32'h0);
    for (int j = 0; j < 4; j++) wr_word(IN_A, 32'h0001_0000);
    cfg_lo(d);
    check("init4_done", 32'(d), 32'h00);
    bus_wr(CFG_A, 8'h04);
    bus_wr(CFG_A, 8'h01);
    load_signal(1);
    wait_idle("wrap_done");
    drain_check(2);

    // Reset in the middle of COMPUTE
    bus_wr(CFG_A, 8'h04);
    bus_wr(CFG_A, 8'h01);
    load_signal(0);
    repeat (20) @(negedge clk);
    cfg_lo(d);
    check("abort_busy", 32'(d[0]), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rd_word(CFG_A, w);
    check("abort_cfg", w, 32'h0);
    rd_word(OUT_A, w);
    check("abort_out", w, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wavelet_accelerator.md
Name: wavelet_accelerator

Overview:
- Memory-mapped multi-level 1-D discrete wavelet transform (DWT) accelerator on a byte-wide CPU bus.
- CPU loads high-pass (HID) and low-pass (LOD) coefficients, then streams an input signal.
- Block runs up to 4 decomposition levels with dual MAC filtering, periodic extension and downsample-by-2.
- CPU polls status and reads the results back through an output register.

Parameters:
INPUT_WIDTH, 32, sample/coefficient/result word width (signed fixed point)
IBUFF_CELL_COUNT, 4096, input/scratch buffer words (two 2048-word banks)
OBUFF_CELL_COUNT, 4096, output buffer words
DATA_BUS_WIDTH, 8, CPU data bus width
ADDR_BUS_WIDTH, 32, CPU address bus width
BASE_ADDRESS, 32'h1A100000, block decodes when addr[31:4]==BASE_ADDRESS[31:4]
CONFIG_REG_OFFSET, 2'b00, addr[3:2] select for CONFIG
INPUT_REG_OFFSET, 2'b01, addr[3:2] select for INPUT
OUTPUT_REG_OFFSET, 2'b10, addr[3:2] select for OUTPUT
MAX_FILTER_SIZE, 32, taps per filter
FRAC_BITS, 16, fractional bits (Q16.16 data and coefficients)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
cpu_data_in  in  8  write byte
cpu_addr_in  in  32  byte address; addr[1:0] = byte lane, little-endian
cpu_read_en_in  in  1  read strobe
cpu_write_en_in  in  1  write strobe, one byte per clk
cpu_data_out  out  8  read byte (combinational)
cpu_data_ready  out  1  read data valid (combinational)

Behaviour:
- Reset: cpu_data_out=0, cpu_data_ready=0, CONFIG=0, all pointers/counters=0, state IDLE.
- Reads:
  - cpu_data_ready = cpu_read_en_in & address hit. Data is combinational, one byte per cycle.
  - A miss gives ready=0 and data=0. Offset 2'b11 reads 0.
- CONFIG (16 bit):
  - Bit map: b0 GO (rd: busy), b1 INIT (rd: busy), b2 RST_RPTR (write-only command, reads 0), b4:3 inputs_len (N=256/512/1024/2048), b6:5 dec_level (L=value+1), b7 OUT_AVAIL (read-only, writes ignored), b12:8 filter_size (F=value+1), b15:13 reserved (read 0).
  - Lane-0 write, all states: if b2=1, out_rptr←0 and the other bits of that write are ignored.
  - Otherwise in IDLE only: store b6:3. b1=1 → INIT_LOAD. Else b0=1 → GO_LOAD, which also clears out_count.
  - Lane-1 write: stores filter_size in IDLE only.
  - Config writes in other states are ignored except RST_RPTR.
- INPUT register: the byte on lane k goes to word byte k. A lane-3 write commits the word.
  - INIT_LOAD: commits fill HID[0..F-1], then LOD[0..F-1]. After 2F commits, INIT clears and state returns to IDLE.
  - GO_LOAD: commits fill bank A[0..N-1]. The Nth commit enters COMPUTE.
  - In IDLE/COMPUTE: commits are dropped.
- COMPUTE, per level l=1..L, source length M=N>>(l-1), k=0..M/2-1:
  - D[k] = Σj HID[j]·x[(2k+j) mod M]; A[k] = same with LOD.
  - Products are 64-bit signed, accumulated in 69 bits. Result = acc >>> FRAC_BITS, truncated to 32 bits, no saturation.
  - Two MACs run in parallel, one tap per cycle: F cycles per k, plus at most 2 pipeline cycles.
  - D is appended to the output buffer. A goes to the other bank (ping-pong), which becomes the next level's source.
  - After level L, the final A values are appended.
  - Output order: D1, D2, …, DL, AL. Total words = N.
  - GO clears the cycle after the last append; state returns to IDLE.
- OUTPUT register:
  - Reads buf[out_rptr] byte by lane.
  - A lane-3 read with OUT_AVAIL=1 increments out_rptr at that clock edge.
  - OUT_AVAIL = (out_rptr != out_count).
  - When empty, output reads return 0 and the pointer holds.
- Simultaneous read and write: both are honoured. A write to CONFIG takes effect the next cycle.
- Asserting rst mid-operation aborts everything and returns all state to reset values.

Decomposition:
- Package wavelet_accel_pkg:
  - register offsets and CONFIG bit positions;
  - state enum {IDLE, INIT_LOAD, GO_LOAD, COMPUTE};
  - inputs_len→N decode function;
  - FRAC_BITS and accumulator width constants.
- Sub-module wavelet_filter_engine: dual MAC, tap/k/level counters, periodic index generation, ping-pong addressing.
- The top level holds bus decode, CONFIG, buffers and the state machine.

Test Plan:
- Reset, then read CONFIG → 0x0000 and cpu_data_ready=1. A read at a non-matching address → ready 0.
- Write lane0=0xF8, lane1=0x1F → CONFIG reads 0x1F78 (b7 ignored, OUT_AVAIL=0).
- F=2 init: write 4 words → INIT reads 1 after 3 commits and 0 after the 4th.
- Haar check:
  - Setup: F=2, HID={0x00010000,0xFFFF0000}, LOD={0x00010000,0x00010000}, N=256, L=1, x[i]=i<<16.
  - Expect 256 outputs: the first 128 are 0xFFFF0000, output 129 is 0x00010000, the last is 0x01FD0000.
  - OUT_AVAIL drops to 0 after word 256; a further output read gives 0.
- Wrap-around: F=4, LOD all 1.0, HID 0, x=1.0 at index 0 only, N=256, L=1 → A[0]=A[127]=0x00010000, all other A=0.
- RST_RPTR after a full drain → OUT_AVAIL=1 and the first word rereads the same. rst pulse during COMPUTE → CONFIG=0 and no outputs.
